// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory port.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W,
    SIZE_D
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RREQ,
    RWAIT,
    WREQ,
    WWAIT,
    RESP,
    ERR
  } state_e;

  // Bytes touched by an access of the given size starting at byte offset off.
  function automatic logic [7:0] byte_mask(input size_e size, input logic [2:0] off);
    logic [7:0] m;
    unique case (size)
      SIZE_B: m = 8'h01;
      SIZE_H: m = 8'h03;
      SIZE_W: m = 8'h0f;
      SIZE_D: m = 8'hff;
    endcase
    return m << off;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [2:0] off);
    logic mis;
    unique case (size)
      SIZE_B: mis = 1'b0;
      SIZE_H: mis = off[0];
      SIZE_W: mis = |off[1:0];
      SIZE_D: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane extraction: shift the addressed bytes down, then sign/zero extend.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [63:0] result
);

  logic [63:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    result  = shifted;
    unique case (size)
      SIZE_B: result = {{56{~uns & shifted[7]}}, shifted[7:0]};
      SIZE_H: result = {{48{~uns & shifted[15]}}, shifted[15:0]};
      SIZE_W: result = {{32{~uns & shifted[31]}}, shifted[31:0]};
      SIZE_D: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for a single-port word memory with one-cycle response.
// Sub-doubleword stores are done as read-modify-write of the containing word.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH+2:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_valid,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e          state_q, state_d;
  logic            wen_q;
  logic [2:0]      off_q;
  size_e           size_q;
  logic            uns_q;
  logic [63:0]     wdata_q;

  size_e           req_size_e;
  logic            accept;
  logic            rd_done;
  logic [7:0]      mask;
  logic [63:0]     wdata_shifted;
  logic [63:0]     merged;
  logic [63:0]     load_data;

  assign req_size_e = size_e'(req_size);
  assign req_ready  = (state_q == IDLE);
  assign accept     = req_ready && req_valid;
  assign rd_done    = (state_q == RWAIT) && mem_rvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_misaligned(req_size_e, req_addr[2:0])) begin
            state_d = ERR;
          end else if (req_wen && (req_size_e == SIZE_D)) begin
            state_d = WREQ;
          end else begin
            state_d = RREQ;
          end
        end
      end
      RREQ:  state_d = RWAIT;
      RWAIT: if (mem_rvalid) state_d = wen_q ? WREQ : RESP;
      WREQ:  state_d = WWAIT;
      WWAIT: if (mem_rvalid) state_d = RESP;
      RESP:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Masked bytes come from the shifted store data, the rest from the old word.
  always_comb begin
    mask          = byte_mask(size_q, off_q);
    wdata_shifted = wdata_q << {off_q, 3'b000};
    merged        = '0;
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = mask[i] ? wdata_shifted[8*i +: 8] : mem_rdata[8*i +: 8];
    end
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .size   (size_q),
    .uns    (uns_q),
    .result (load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      off_q      <= '0;
      size_q     <= SIZE_B;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Outputs are registered from the next state so they align with it.
      mem_valid  <= (state_d == RREQ) || (state_d == WREQ);
      mem_wen    <= (state_d == WREQ);
      resp_valid <= (state_d == RESP) || (state_d == ERR);
      resp_error <= (state_d == ERR);
      resp_rdata <= (rd_done && !wen_q) ? load_data : '0;

      if (accept) begin
        wen_q    <= req_wen;
        off_q    <= req_addr[2:0];
        size_q   <= req_size_e;
        uns_q    <= req_unsigned;
        wdata_q  <= req_wdata;
        mem_addr <= req_addr[ADDR_WIDTH+2:3];
        if (req_wen && (req_size_e == SIZE_D)) begin
          mem_wdata <= req_wdata;
        end
      end

      if (rd_done && wen_q) begin
        mem_wdata <= merged;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port with a delay-configurable memory model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [18:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        mem_valid;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_port #(
    .DATA_WIDTH (64),
    .ADDR_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_valid    (mem_valid),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  // Memory model: read returns the old word; completion after 1 + dly cycles.
  logic [63:0] mem [0:15];
  int          dly = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [63:0] pre_data = '0;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pre_en) mem[pre_addr] <= pre_data;
    if (mem_valid) begin
      mem_rdata <= mem[mem_addr[3:0]];
      if (mem_wen) mem[mem_addr[3:0]] <= mem_wdata;
      if (dly == 0) begin
        mem_rvalid <= 1'b1;
      end else begin
        pend <= 1'b1;
        cnt  <= dly - 1;
      end
    end else if (pend) begin
      if (cnt == 0) begin
        mem_rvalid <= 1'b1;
        pend       <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  logic [63:0] ref_mem [0:15];

  function automatic logic [63:0] ref_load(input logic [63:0] w, input int off, input int size,
                                           input bit uns);
    int          bits;
    logic [63:0] v;
    logic [63:0] m;
    bits = 8 << size;
    v    = w >> (8 * off);
    if (bits < 64) begin
      m = (64'd1 << bits) - 64'd1;
      v = v & m;
      if (!uns && v[bits-1]) v = v | ~m;
    end
    return v;
  endfunction

  function automatic logic [63:0] ref_store(input logic [63:0] w, input logic [63:0] d,
                                            input int off, input int size);
    logic [63:0] r;
    r = w;
    for (int b = 0; b < 8; b++) begin
      if (b >= off && b < off + (1 << size)) r[8*b +: 8] = d[8*(b-off) +: 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", name, obs, exp);
    end
  endtask

  task automatic run_req(input bit wen, input logic [18:0] addr, input int size, input bit uns,
                         input logic [63:0] wdata, input int d, input bit hold,
                         output logic [63:0] got_rdata, output logic got_err);
    int          off, nb, wa, exp_rc, exp_np, exp_c2;
    bit          mis, sub_store;
    logic [63:0] old, exp_r, exp_word;
    int          rc, nr, np, c1, c2, w;
    logic        w1, w2;
    logic [15:0] a1, a2;
    logic [63:0] wd1, wd2;
    off = int'(addr[2:0]);
    nb  = 1 << size;
    wa  = int'(addr[18:3]);
    mis = (off % nb) != 0;
    old = ref_mem[wa[3:0]];
    sub_store = wen && (size != 3);
    exp_word  = ref_store(old, wdata, off, size);
    exp_r     = (mis || wen) ? 64'd0 : ref_load(old, off, size, uns);
    if (mis) begin
      exp_rc = 1; exp_np = 0; exp_c2 = 0;
    end else if (sub_store) begin
      exp_rc = 5 + 2 * d; exp_np = 2; exp_c2 = 3 + d;
    end else begin
      exp_rc = 3 + d; exp_np = 1; exp_c2 = 0;
    end
    rc = 0; nr = 0; np = 0; c1 = 0; c2 = 0; w1 = 0; w2 = 0;
    a1 = '0; a2 = '0; wd1 = '0; wd2 = '0; got_rdata = '0; got_err = 1'b0;

    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ready_idle", 64'(req_ready), 64'd1);
    dly          = d;
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_size     = 2'(size);
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    #1;
    if (hold) begin
      // Busy-period requests must be ignored, and latched fields must not move.
      req_wen      = 1'($urandom);
      req_addr     = 19'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = {$urandom, $urandom};
    end else begin
      req_valid = 1'b0;
    end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) check("ready_busy", 64'(req_ready), 64'd0);
      if (mem_valid) begin
        np++;
        if (np == 1) begin
          c1 = c; w1 = mem_wen; a1 = mem_addr; wd1 = mem_wdata;
        end else if (np == 2) begin
          c2 = c; w2 = mem_wen; a2 = mem_addr; wd2 = mem_wdata;
        end
      end
      if (resp_valid) begin
        nr++;
        if (rc == 0) begin
          rc = c; got_rdata = resp_rdata; got_err = resp_error;
        end
      end
      if (rc != 0 && c == rc) req_valid = 1'b0;
      if (rc != 0 && c == rc + 1) begin
        check("ready_after", 64'(req_ready), 64'd1);
        break;
      end
    end
    req_valid = 1'b0;
    dly       = 0;

    check("resp_cycle", 64'(rc), 64'(exp_rc));
    check("resp_count", 64'(nr), 64'd1);
    check("resp_rdata", got_rdata, exp_r);
    check("resp_error", 64'(got_err), 64'(mis));
    check("mem_pulses", 64'(np), 64'(exp_np));
    if (exp_np >= 1) begin
      check("mem_c1", 64'(c1), 64'd1);
      check("mem_a1", 64'(a1), 64'(wa));
      check("mem_w1", 64'(w1), 64'(wen && !sub_store));
      if (wen && !sub_store) check("mem_wd1", wd1, exp_word);
    end
    if (exp_np == 2) begin
      check("mem_c2", 64'(c2), 64'(exp_c2));
      check("mem_a2", 64'(a2), 64'(wa));
      check("mem_w2", 64'(w2), 64'd1);
      check("mem_wd2", wd2, exp_word);
    end
    if (wen && !mis) ref_mem[wa[3:0]] = exp_word;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    logic        e;
    int          n;

    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = 4'(i);
      pre_data = (i == 0) ? 64'h8877_6655_4433_2211 : {$urandom, $urandom};
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
    @(negedge clk);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b1;

    run_req(1'b0, 19'h7, 0, 1'b0, 64'd0, 0, 1'b0, r, e);
    check("ld_b7_signed", r, 64'hFFFF_FFFF_FFFF_FF88);
    run_req(1'b0, 19'h6, 1, 1'b1, 64'd0, 0, 1'b0, r, e);
    check("ld_h6_unsigned", r, 64'h0000_0000_0000_8877);
    run_req(1'b0, 19'h4, 2, 1'b0, 64'd0, 0, 1'b0, r, e);
    check("ld_w4_signed", r, 64'hFFFF_FFFF_8877_6655);
    run_req(1'b1, 19'h2, 0, 1'b0, 64'hAB, 0, 1'b0, r, e);
    run_req(1'b0, 19'h0, 3, 1'b0, 64'd0, 0, 1'b0, r, e);
    check("ld_d0_merged", r, 64'h8877_6655_44AB_2211);
    run_req(1'b1, 19'h8, 3, 1'b0, 64'h0123_4567_89AB_CDEF, 0, 1'b0, r, e);
    run_req(1'b0, 19'h8, 3, 1'b0, 64'd0, 0, 1'b0, r, e);
    check("ld_d8", r, 64'h0123_4567_89AB_CDEF);
    run_req(1'b0, 19'h2, 2, 1'b0, 64'd0, 0, 1'b0, r, e);
    check("misaligned_err", 64'(e), 64'd1);
    run_req(1'b0, 19'h4, 2, 1'b1, 64'd0, 3, 1'b1, r, e);
    check("stall_ld_w4", r, 64'h0000_0000_8877_6655);
    run_req(1'b1, 19'h16, 1, 1'b0, 64'hBEEF, 2, 1'b1, r, e);

    for (int t = 0; t < 80; t++) begin
      run_req(1'($urandom), {12'd0, 4'($urandom_range(0, 15)), 3'($urandom)},
              int'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom},
              int'($urandom_range(0, 2)), 1'($urandom), r, e);
    end

    // Reset in cycle 2 of a sub-word store: aborts with no response and no write.
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 19'h2;
    req_size  = 2'd0;
    req_wdata = 64'hCD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_valid", 64'(mem_valid), 64'd0);
    check("abort_mem_wen", 64'(mem_wen), 64'd0);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_resp_error", 64'(resp_error), 64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_mem_wdata", mem_wdata, 64'd0);
    check("abort_resp_rdata", resp_rdata, 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid || mem_valid) n++;
    end
    check("abort_quiet", 64'(n), 64'd0);
    run_req(1'b0, 19'h0, 3, 1'b0, 64'd0, 0, 1'b0, r, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator driving the core's single-port word memory (valid/wen/addr/wdata in, rvalid/rdata out, one-cycle response). Accepts byte-addressed, sized load/store requests from the pipeline. Performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-doubleword stores. Returns one registered response per request.

## Interface
- DATA_WIDTH, 64, memory word width; only 64 is supported.
- ADDR_WIDTH, 16, memory word-address width; byte address is ADDR_WIDTH+3 bits.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; request accepted on edge where req_valid && req_ready.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH+3  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  zero-extend load (ignored for stores and size 3).
- req_wdata  in  64  store data, right-aligned in low bits.
- resp_valid  out  1  one-cycle pulse; no backpressure.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_error  out  1  misaligned request.
- mem_valid  out  1  memory request, exactly one cycle per access.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  word address = req_addr[ADDR_WIDTH+2:3].
- mem_wdata  out  64  full word to write.
- mem_rvalid  in  1  memory completion, one cycle after mem_valid.
- mem_rdata  in  64  old word at mem_addr.

## Operation
- Request fields latched on accept. off = req_addr[2:0]. Misaligned when off mod 2^size != 0: no memory access; resp_error=1.
- FSM states and transitions:
  - IDLE: on accept, go to ERR if misaligned, WREQ if store with size 3, else RREQ.
  - RREQ: mem_valid=1, mem_wen=0; go to RWAIT.
  - RWAIT: on mem_rvalid, capture mem_rdata. Load → RESP. Store → WREQ with merged word.
  - WREQ: mem_valid=1, mem_wen=1; go to WWAIT.
  - WWAIT: on mem_rvalid → RESP; mem_rdata ignored.
  - RESP, ERR: resp_valid=1 for that cycle; go to IDLE.
- Load data: take (rdata >> 8*off), keep 8·2^size bits, then sign-extend unless req_unsigned.
- Store merge: byte mask ((1<<2^size)-1) << off. Mask bytes come from (wdata << 8*off); all other bytes come from the captured old word.
- mem_valid, mem_wen, mem_addr, mem_wdata, resp_* are registered outputs. mem_valid and resp_valid are low outside the states listed above.
- mem_rvalid outside RWAIT/WWAIT is ignored.

## Timing
- Reset (rst=0 at edge): state IDLE; mem_valid, mem_wen, resp_valid, resp_error 0; mem_addr, mem_wdata, resp_rdata 0; req_ready 1 in the following cycle.
- Reset mid-operation aborts with no response. A write already sampled by memory is not undone.
- Cycle 0 is the cycle of the accept edge.
- Load: mem_valid in cycle 1, mem_rvalid in cycle 2, resp_valid in cycle 3; req_ready high again in cycle 4.
- Doubleword store: mem_valid/wen in cycle 1, mem_rvalid in cycle 2, resp_valid in cycle 3.
- Sub-doubleword store: read in cycle 1, write in cycle 3, resp_valid in cycle 5.
- Misaligned request: resp_valid in cycle 1.
- Stalled mem_rvalid holds RWAIT/WWAIT indefinitely; mem_valid is not reissued.
- req_valid while not ready is ignored; no queueing.

## Structure
- Package lsu_pkg holds:
  - size enum (SIZE_B, SIZE_H, SIZE_W, SIZE_D);
  - state enum (IDLE, RREQ, RWAIT, WREQ, WWAIT, RESP, ERR);
  - function returning byte mask from size/offset.
- Sub-module lsu_load_align: combinational extract plus sign/zero extend (rdata, off, size, unsigned → 64-bit result).
- FSM and store merge stay in lsu_mem_port.

## Test plan
- Preload word 0 = 0x8877665544332211. Load byte at addr 0x7, signed → resp_rdata 0xFFFFFFFFFFFFFF88, resp_valid in cycle 3.
- Same word, load half at 0x6, unsigned → 0x0000000000008877. Load word at 0x4, signed → 0xFFFFFFFF88776655.
- Store byte 0xAB at 0x2, then load double at 0x0 → 0x88776655 44AB2211. Two mem_valid pulses, in cycles 1 and 3.
- Store double 0x0123456789ABCDEF at 0x8 → single write cycle, resp in cycle 3. A subsequent load returns the same value.
- Load word at 0x2 (misaligned) → resp_error=1 and resp_rdata=0 in cycle 1; mem_valid never asserted.
- Pull rst low in cycle 2 of a sub-word store → no resp_valid. Cycle after reset: all outputs 0 and req_ready=1. Following load completes normally.
